ssd_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for a 4-digit (parameterised) common-anode seven-segment display.
- Shares one combinational hex-to-segment decoder across all digits: drives its nibble input, registers its segment output, and sequences the digit enables.
- Provides tear-free value updates latched at frame boundaries, plus optional leading-zero blanking.
- Sits between the user logic and the output pins of the design.

---
 rtl/ssd_scan_ctrl_if.sv | 28 ++
 rtl/ssd_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ssd_scan_ctrl_if.sv
// Signal bundle between the user logic / shared segment decoder and the
// seven-segment scan controller.
interface ssd_scan_ctrl_if #(
    parameter int DIGITS = 4,
    parameter int DIV_W  = 16
);
    logic                  ena;
    logic [4*DIGITS-1:0]   value_in;
    logic                  load;
    logic                  lz_blank;
    logic [DIV_W-1:0]      div;
    logic [3:0]            nib;
    logic [6:0]            seg_in;
    logic [6:0]            seg_out;
    logic [DIGITS-1:0]     dig_sel;
    logic                  pending;
    logic                  frame_done;

    modport master (
        output ena, value_in, load, lz_blank, div, seg_in,
        input  nib, seg_out, dig_sel, pending, frame_done
    );

    modport slave (
        input  ena, value_in, load, lz_blank, div, seg_in,
        output nib, seg_out, dig_sel, pending, frame_done
    );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scan controller with a shared
// external decoder, frame-boundary value updates and leading-zero blanking.
module ssd_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV_W  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    ssd_scan_ctrl_if.slave  bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ALL_OFF  = {DIGITS{1'b1}};
    localparam logic [6:0]        SEG_DARK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [IDX_W-1:0]    idx_r, idx_s;
    logic [DIV_W-1:0]    cnt_r, cnt_s;
    logic [4*DIGITS-1:0] disp_r, disp_s;
    logic [4*DIGITS-1:0] pend_val_r, pend_val_s;
    logic                pending_r, pending_s;
    logic                frame_done_r, frame_done_s;
    logic [6:0]          seg_out_r, seg_out_s;
    logic [DIGITS-1:0]   dig_sel_r, dig_sel_s;

    // A digit is dark when it and every more significant nibble are zero.
    function automatic logic lz_suppress(input logic [4*DIGITS-1:0] d,
                                         input logic [IDX_W-1:0]    i,
                                         input logic                en);
        logic all_zero;
        all_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            all_zero = all_zero & ((j < int'(i)) | (d[4*j +: 4] == 4'h0));
        end
        return en & (i != '0) & all_zero;
    endfunction

    assign bus.nib        = disp_r[{idx_r, 2'b00} +: 4];
    assign bus.seg_out    = seg_out_r;
    assign bus.dig_sel    = dig_sel_r;
    assign bus.pending    = pending_r;
    assign bus.frame_done = frame_done_r;

    // Next-state, scan sequencing and value-update logic.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        cnt_s        = cnt_r;
        disp_s       = disp_r;
        pend_val_s   = pend_val_r;
        pending_s    = pending_r;
        frame_done_s = 1'b0;
        seg_out_s    = seg_out_r;
        dig_sel_s    = dig_sel_r;

        case (state_r)
            IDLE: begin
                idx_s     = '0;
                cnt_s     = '0;
                seg_out_s = SEG_DARK;
                dig_sel_s = ALL_OFF;
                // Nothing is on screen, so a waiting value can go live at once.
                if (pending_r) begin
                    disp_s    = pend_val_r;
                    pending_s = 1'b0;
                end else begin
                    disp_s    = disp_r;
                end
                state_s = bus.ena ? BLANK : IDLE;
            end
            BLANK: begin
                if (bus.ena) begin
                    state_s   = SHOW;
                    cnt_s     = '0;
                    seg_out_s = lz_suppress(disp_r, idx_r, bus.lz_blank) ? SEG_DARK : bus.seg_in;
                    dig_sel_s = ~(DIGITS'(1) << idx_r);
                end else begin
                    state_s   = IDLE;
                    idx_s     = '0;
                    cnt_s     = '0;
                    seg_out_s = SEG_DARK;
                    dig_sel_s = ALL_OFF;
                end
            end
            SHOW: begin
                if (!bus.ena) begin
                    state_s   = IDLE;
                    idx_s     = '0;
                    cnt_s     = '0;
                    seg_out_s = SEG_DARK;
                    dig_sel_s = ALL_OFF;
                end else if (cnt_r >= bus.div) begin
                    state_s   = BLANK;
                    seg_out_s = SEG_DARK;
                    dig_sel_s = ALL_OFF;
                    if (idx_r == LAST_IDX) begin
                        idx_s        = '0;
                        frame_done_s = 1'b1;
                        if (pending_r) begin
                            disp_s    = pend_val_r;
                            pending_s = 1'b0;
                        end else begin
                            disp_s    = disp_r;
                        end
                    end else begin
                        idx_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    cnt_s = cnt_r + DIV_W'(1);
                end
            end
            default: begin
                state_s   = IDLE;
                idx_s     = '0;
                cnt_s     = '0;
                seg_out_s = SEG_DARK;
                dig_sel_s = ALL_OFF;
            end
        endcase

        // A load on the boundary edge still re-arms pending with the new value.
        if (bus.load) begin
            pend_val_s = bus.value_in;
            pending_s  = 1'b1;
        end else begin
            pend_val_s = pend_val_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            idx_r        <= '0;
            cnt_r        <= '0;
            disp_r       <= '0;
            pend_val_r   <= '0;
            pending_r    <= 1'b0;
            frame_done_r <= 1'b0;
            seg_out_r    <= SEG_DARK;
            dig_sel_r    <= ALL_OFF;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            cnt_r        <= cnt_s;
            disp_r       <= disp_s;
            pend_val_r   <= pend_val_s;
            pending_r    <= pending_s;
            frame_done_r <= frame_done_s;
            seg_out_r    <= seg_out_s;
            dig_sel_r    <= dig_sel_s;
        end
    end
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed self-checking bench for ssd_scan_ctrl with a behavioural hex decoder
// wired onto the nib/seg_in loop.
module tb_ssd_scan_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ssd_scan_ctrl_if #(.DIGITS(4), .DIV_W(16)) bus ();

    ssd_scan_ctrl #(.DIGITS(4), .DIV_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic logic [6:0] hex_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  4'hF: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    assign bus.seg_in = hex_seg(bus.nib);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [15:0] v);
        bus.value_in = v;
        bus.load     = 1'b1;
        step();
        bus.load     = 1'b0;
    endtask

    task automatic wait_frame_done(input int bound);
        int n;
        n = 0;
        while (n < bound && bus.frame_done !== 1'b1) begin
            step();
            n++;
        end
        check_eq("frame_done_wait", {31'd0, bus.frame_done}, 32'd1);
    endtask

    // Starts and ends on a frame_done sample; assumes div=3.
    task automatic check_frame(input logic [15:0] v, input logic lz);
        logic [3:0]  exp_dig;
        logic [6:0]  exp_seg;
        logic [15:0] upper;
        for (int d = 0; d < 4; d++) begin
            exp_dig    = 4'hF;
            exp_dig[d] = 1'b0;
            upper      = v >> (4 * d);
            exp_seg    = (lz && d != 0 && upper == 16'h0000) ? 7'h7F : hex_seg(upper[3:0]);
            for (int k = 0; k < 4; k++) begin
                step();
                check_eq($sformatf("dig_sel_d%0d", d), {28'd0, bus.dig_sel}, {28'd0, exp_dig});
                check_eq($sformatf("seg_out_d%0d", d), {25'd0, bus.seg_out}, {25'd0, exp_seg});
            end
            step();
            check_eq($sformatf("blank_dig_d%0d", d), {28'd0, bus.dig_sel}, 32'h0000000F);
            check_eq($sformatf("blank_seg_d%0d", d), {25'd0, bus.seg_out}, 32'h0000007F);
            check_eq($sformatf("frame_done_d%0d", d), {31'd0, bus.frame_done}, (d == 3) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic check_dark(input string tag);
        check_eq({tag, "_dig"}, {28'd0, bus.dig_sel}, 32'h0000000F);
        check_eq({tag, "_seg"}, {25'd0, bus.seg_out}, 32'h0000007F);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.ena      = 1'b0;
        bus.value_in = 16'h0000;
        bus.load     = 1'b0;
        bus.lz_blank = 1'b0;
        bus.div      = 16'd3;
        #12;
        check_dark("reset");
        check_eq("reset_pending", {31'd0, bus.pending}, 32'd0);
        check_eq("reset_frame_done", {31'd0, bus.frame_done}, 32'd0);
        check_eq("reset_nib", {28'd0, bus.nib}, 32'd0);
        step();
        rst_n = 1'b1;

        // Basic scan of 12AF after the first boundary.
        bus.ena = 1'b1;
        pulse_load(16'h12AF);
        check_eq("pending_after_load", {31'd0, bus.pending}, 32'd1);
        wait_frame_done(50);
        check_eq("pending_cleared", {31'd0, bus.pending}, 32'd0);
        check_eq("nib_after_copy", {28'd0, bus.nib}, 32'hF);
        check_frame(16'h12AF, 1'b0);

        // Leading-zero suppression.
        pulse_load(16'h0070);
        wait_frame_done(30);
        bus.lz_blank = 1'b1;
        check_frame(16'h0070, 1'b1);
        pulse_load(16'h0000);
        wait_frame_done(30);
        check_frame(16'h0000, 1'b1);
        bus.lz_blank = 1'b0;

        // Last load before the boundary wins.
        repeat (3) step();
        pulse_load(16'h1111);
        check_eq("pending_1111", {31'd0, bus.pending}, 32'd1);
        repeat (2) step();
        pulse_load(16'h2222);
        check_eq("pending_2222", {31'd0, bus.pending}, 32'd1);
        wait_frame_done(30);
        check_eq("pending_clr_2222", {31'd0, bus.pending}, 32'd0);
        check_eq("nib_2222", {28'd0, bus.nib}, 32'h2);
        check_frame(16'h2222, 1'b0);

        // Load coinciding with the boundary edge.
        pulse_load(16'h3333);
        repeat (18) step();
        bus.value_in = 16'h4444;
        bus.load     = 1'b1;
        step();
        bus.load     = 1'b0;
        check_eq("fd_on_load_edge", {31'd0, bus.frame_done}, 32'd1);
        check_eq("pending_kept", {31'd0, bus.pending}, 32'd1);
        check_eq("nib_3333", {28'd0, bus.nib}, 32'h3);
        check_frame(16'h3333, 1'b0);
        check_eq("pending_clr_4444", {31'd0, bus.pending}, 32'd0);
        check_eq("nib_4444", {28'd0, bus.nib}, 32'h4);
        check_frame(16'h4444, 1'b0);

        // Drop ena during digit 2 dwell.
        repeat (12) step();
        check_eq("pre_drop_dig", {28'd0, bus.dig_sel}, 32'hB);
        bus.ena = 1'b0;
        step();
        check_dark("ena_drop");
        check_eq("ena_drop_fd", {31'd0, bus.frame_done}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_dark("ena_low");
            check_eq("ena_low_fd", {31'd0, bus.frame_done}, 32'd0);
        end
        bus.ena = 1'b1;
        step();
        check_dark("reen_blank");
        check_eq("reen_nib", {28'd0, bus.nib}, 32'h4);
        step();
        check_eq("reen_dig", {28'd0, bus.dig_sel}, 32'hE);
        check_eq("reen_seg", {25'd0, bus.seg_out}, {25'd0, hex_seg(4'h4)});

        // Lower div mid-dwell.
        bus.div = 16'd100;
        repeat (10) step();
        check_eq("long_dwell_dig", {28'd0, bus.dig_sel}, 32'hE);
        bus.div = 16'd0;
        step();
        check_dark("div0_exit");
        step();
        check_eq("div0_d1", {28'd0, bus.dig_sel}, 32'hD);
        step();
        check_eq("div0_b1", {28'd0, bus.dig_sel}, 32'hF);
        step();
        check_eq("div0_d2", {28'd0, bus.dig_sel}, 32'hB);
        step();
        check_eq("div0_b2", {28'd0, bus.dig_sel}, 32'hF);
        step();
        check_eq("div0_d3", {28'd0, bus.dig_sel}, 32'h7);

        // Asynchronous reset mid-SHOW.
        #2;
        rst_n = 1'b0;
        #1;
        check_dark("async_rst");
        check_eq("async_rst_pending", {31'd0, bus.pending}, 32'd0);
        #10;
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
